// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: fixed-priority arbiter and single timing engine for the
// multiplexed 8-bit RTC bus (AD/RD/WR/CS). Each grant runs one complete
// address + data bus cycle, then returns to IDLE for re-arbitration.
module rtc_bus_scheduler #(
  parameter int unsigned T_ADDR = 4,
  parameter int unsigned T_GAP  = 2,
  parameter int unsigned T_DATA = 6,
  parameter int unsigned T_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  req_wr,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic [7:0]  bus_in,
  output logic        ad_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        cs_n,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 8;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_DATA = CNT_W'(T_DATA - 1);
  localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            lat_wr;

  logic [2:0]      pick_oh;
  logic [DW-1:0]   pick_addr;
  logic [DW-1:0]   pick_wdata;
  logic            pick_wr;
  logic            cnt_zero;

  assign cnt_zero = (cnt == '0);

  // Fixed-priority pick: lowest-index active request wins.
  always_comb begin
    pick_oh    = 3'b000;
    pick_addr  = req_addr[7:0];
    pick_wdata = req_wdata[7:0];
    pick_wr    = req_wr[0];
    if (req[0]) begin
      pick_oh = 3'b001;
    end else if (req[1]) begin
      pick_oh    = 3'b010;
      pick_addr  = req_addr[15:8];
      pick_wdata = req_wdata[15:8];
      pick_wr    = req_wr[1];
    end else if (req[2]) begin
      pick_oh    = 3'b100;
      pick_addr  = req_addr[23:16];
      pick_wdata = req_wdata[23:16];
      pick_wr    = req_wr[2];
    end
  end

  // Phase sequencer; every output is registered and set on phase entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      ad_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          ad_n   <= 1'b1;
          rd_n   <= 1'b1;
          wr_n   <= 1'b1;
          cs_n   <= 1'b1;
          bus_oe <= 1'b0;
          if (|req) begin
            state     <= S_ADDR;
            cnt       <= LD_ADDR;
            gnt       <= pick_oh;
            lat_addr  <= pick_addr;
            lat_wdata <= pick_wdata;
            lat_wr    <= pick_wr;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            ad_n      <= 1'b0;
            bus_oe    <= 1'b1;
            bus_out   <= pick_addr;
          end
        end

        S_ADDR: begin
          if (cnt_zero) begin
            state  <= S_GAP;
            cnt    <= LD_GAP;
            ad_n   <= 1'b1;
            bus_oe <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_GAP: begin
          if (cnt_zero) begin
            state <= S_DATA;
            cnt   <= LD_DATA;
            if (lat_wr) begin
              wr_n    <= 1'b0;
              bus_oe  <= 1'b1;
              bus_out <= lat_wdata;
            end else begin
              rd_n <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_zero) begin
            state <= S_HOLD;
            cnt   <= LD_HOLD;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            // Read data is sampled on the last strobe-low cycle.
            if (!lat_wr) begin
              rdata <= bus_in;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt_zero) begin
            state  <= S_DONE;
            cnt    <= '0;
            cs_n   <= 1'b1;
            bus_oe <= 1'b0;
            done   <= gnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          gnt    <= '0;
          busy   <= 1'b0;
          ad_n   <= 1'b1;
          rd_n   <= 1'b1;
          wr_n   <= 1'b1;
          cs_n   <= 1'b1;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: directed vector table, hand-written corner
// sequences, and randomized traffic against a phase-offset reference model.
module tb_rtc_bus_scheduler;

  localparam int TA = 4;
  localparam int TG = 2;
  localparam int TD = 6;
  localparam int TH = 2;
  localparam int PA = TA;
  localparam int PG = TA + TG;
  localparam int PD = PG + TD;
  localparam int PH = PD + TH;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  req_wr;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [7:0]  bus_in;
  logic        ad_n, rd_n, wr_n, cs_n, busy;

  always #5 clk = ~clk;

  rtc_bus_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n), .busy(busy)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [7:0]  bin;
    logic [2:0]  exp_done;
    int          exp_cyc;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_done[3];
  int grants = 0;
  int dones = 0;
  logic [2:0] prev_gnt = 3'b000;

  // Reference model: a transaction is an offset into a fixed phase schedule.
  bit         m_act = 1'b0;
  int         m_t = 0;
  int         m_k = 0;
  bit         m_wr = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [27:0] model_exp();
    logic [2:0] g, d;
    logic oe, adn, rdn, wrn, csn;
    logic [7:0] bo;
    g   = m_act ? 3'(1 << m_k) : 3'b000;
    adn = !(m_act && m_t < PA);
    csn = !(m_act && m_t < PH);
    wrn = !(m_act && m_wr && m_t >= PG && m_t < PD);
    rdn = !(m_act && !m_wr && m_t >= PG && m_t < PD);
    oe  = m_act && (m_t < PA || (m_wr && m_t >= PG && m_t < PH));
    d   = (m_act && m_t == PH) ? g : 3'b000;
    bo  = !oe ? 8'h00 : ((m_t < PA) ? m_addr : m_wdata);
    return {g, d, m_rdata, oe, adn, rdn, wrn, csn, m_act, bo};
  endfunction

  task automatic model_update();
    if (reset) begin
      m_act   = 1'b0;
      m_rdata = 8'h00;
    end else if (m_act) begin
      if (!m_wr && m_t == PD - 1) m_rdata = bus_in;
      if (m_t == PH) m_act = 1'b0;
      else m_t++;
    end else if (req != 3'b000) begin
      m_k     = req[0] ? 0 : (req[1] ? 1 : 2);
      m_act   = 1'b1;
      m_t     = 0;
      m_addr  = req_addr[8*m_k +: 8];
      m_wdata = req_wdata[8*m_k +: 8];
      m_wr    = req_wr[m_k];
    end
  endtask

  // One clock cycle: compare at negedge, advance model, land #1 after posedge.
  task automatic step();
    logic [27:0] e, a;
    @(negedge clk);
    e = model_exp();
    a = {gnt, done, rdata, bus_oe, ad_n, rd_n, wr_n, cs_n, busy, (e[13] ? bus_out : 8'h00)};
    chk("cycle_outputs", 32'(a), 32'(e));
    chk("inv_strobes_exclusive", 32'($countones({ad_n, rd_n, wr_n}) >= 2), 32'd1);
    chk("inv_data_strobe_in_cs", 32'((rd_n & wr_n) | !cs_n), 32'd1);
    chk("inv_no_oe_on_read", 32'(!(bus_oe && !rd_n)), 32'd1);
    for (int i = 0; i < 3; i++)
      if (done[i] && first_done[i] < 0) first_done[i] = cyc;
    if (gnt != 3'b000 && prev_gnt == 3'b000) grants++;
    if (done != 3'b000) dones++;
    prev_gnt = gnt;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_done();
    for (int i = 0; i < 3; i++) first_done[i] = -1;
  endtask

  function automatic logic [2:0] done_mask();
    logic [2:0] m;
    for (int i = 0; i < 3; i++) m[i] = (first_done[i] >= 0);
    return m;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    req = v.req; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata; bus_in = v.bin;
    clear_done();
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_mask() != 3'b000) break;
    end
    req = 3'b000;
    step();
    nm = $sformatf("vec%0d_done_who", idx);
    chk(nm, 32'(done_mask()), 32'(v.exp_done));
    nm = $sformatf("vec%0d_done_cycle", idx);
    chk(nm, 32'(first_done[$clog2(v.exp_done)]), 32'(v.exp_cyc));
    nm = $sformatf("vec%0d_rdata", idx);
    chk(nm, 32'(rdata), 32'(v.exp_rdata));
  endtask

  initial begin
    logic [2:0] g17;
    logic [7:0] bo4, bo8;

    vecs[0] = '{req: 3'b010, wr: 3'b010, addr: 24'h000A00, wdata: 24'h002000, bin: 8'h00,
                exp_done: 3'b010, exp_cyc: 15, exp_rdata: 8'h00};
    vecs[1] = '{req: 3'b100, wr: 3'b000, addr: 24'h040000, wdata: 24'h000000, bin: 8'h37,
                exp_done: 3'b100, exp_cyc: 15, exp_rdata: 8'h37};
    vecs[2] = '{req: 3'b001, wr: 3'b001, addr: 24'h000011, wdata: 24'h0000A5, bin: 8'hEE,
                exp_done: 3'b001, exp_cyc: 15, exp_rdata: 8'h37};
    vecs[3] = '{req: 3'b111, wr: 3'b110, addr: 24'h333322, wdata: 24'h777777, bin: 8'hC3,
                exp_done: 3'b001, exp_cyc: 15, exp_rdata: 8'hC3};

    reset = 1'b1; req = 3'b000; req_wr = 3'b000; req_addr = '0; req_wdata = '0; bus_in = 8'h00;
    clear_done();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_bus_out", 32'(bus_out), 32'd0);
    chk("reset_oe_busy", 32'({bus_oe, busy}), 32'd0);
    chk("reset_strobes", 32'({ad_n, rd_n, wr_n, cs_n}), 32'hF);
    step();

    for (int v = 0; v < 4; v++) run_vec(vecs[v], v);

    // Two requesters at once: 0 first, then 2 after 0 withdraws.
    req = 3'b101; req_wr = 3'b000; req_addr = 24'h5A00C3; bus_in = 8'h99;
    clear_done();
    g17 = 3'b000;
    cyc = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (first_done[0] >= 0) req[0] = 1'b0;
      if (cyc == 17) g17 = gnt;
      if (first_done[2] >= 0) break;
    end
    req = 3'b000;
    step();
    chk("prio_done0_cycle", 32'(first_done[0]), 32'd15);
    chk("prio_gnt_at_17", 32'(g17), 32'(3'b100));
    chk("prio_done2_cycle", 32'(first_done[2]), 32'd31);
    chk("prio_rdata", 32'(rdata), 32'h99);

    // Reset in the middle of a write data phase.
    req = 3'b010; req_wr = 3'b010; req_addr = 24'h000A00; req_wdata = 24'h002000;
    clear_done();
    cyc = 0;
    repeat (9) step();
    reset = 1'b1;
    req = 3'b000;
    step();
    reset = 1'b0;
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_busy_oe", 32'({busy, bus_oe}), 32'd0);
    chk("rst_mid_strobes", 32'({ad_n, rd_n, wr_n, cs_n}), 32'hF);
    repeat (12) step();
    chk("rst_mid_no_done", 32'(done_mask()), 32'd0);
    run_vec(vecs[0], 4);

    // Requester drops req and changes its address after the grant.
    req = 3'b010; req_wr = 3'b010; req_addr = 24'h000A00; req_wdata = 24'h005500;
    clear_done();
    bo4 = 8'h00; bo8 = 8'h00;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cyc == 3) begin
        req = 3'b000; req_addr = 24'hFFFFFF; req_wdata = 24'h000000;
      end
      if (cyc == 4) bo4 = bus_out;
      if (cyc == 8) bo8 = bus_out;
      if (first_done[1] >= 0) break;
    end
    step();
    chk("drop_addr_kept", 32'(bo4), 32'h0A);
    chk("drop_wdata_kept", 32'(bo8), 32'h55);
    chk("drop_done_cycle", 32'(first_done[1]), 32'd15);

    // Randomized traffic against the model.
    grants = 0;
    dones = 0;
    for (int i = 0; i < 40000 && grants < 1000; i++) begin
      req       = ($urandom_range(0, 3) != 0) ? 3'($urandom) : 3'b000;
      req_wr    = 3'($urandom);
      req_addr  = 24'($urandom);
      req_wdata = 24'($urandom);
      bus_in    = 8'($urandom);
      step();
    end
    req = 3'b000;
    repeat (20) step();
    chk("rand_grant_count_reached", 32'(grants >= 1000), 32'd1);
    chk("rand_one_done_per_grant", 32'(dones), 32'(grants));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
